// File: rtl/ast_threshold_ctrl.sv
// Per-frame threshold/enable scheduler for the AST corner detector.
// Counts corner strobes over a frame plus a drain window, then steps the threshold toward a target band.
module ast_threshold_ctrl #(
  parameter logic [7:0] T_RESET      = 8'd35,
  parameter int         DRAIN_CYCLES = 64,
  parameter int         CNT_W        = 16
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             fv,
  input  logic             qv,
  input  logic             en_req,
  input  logic             auto_en,
  input  logic [7:0]       t_init,
  input  logic [7:0]       t_min,
  input  logic [7:0]       t_max,
  input  logic [3:0]       step,
  input  logic [CNT_W-1:0] target_lo,
  input  logic [CNT_W-1:0] target_hi,
  output logic [7:0]       t,
  output logic             en,
  output logic [CNT_W-1:0] frame_corners,
  output logic             frame_done,
  output logic             cnt_sat,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME  = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam int               DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            state;
  logic              fv_d;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  count;
  logic              sat;
  logic              rise;
  logic              fall;

  logic [CNT_W-1:0]  cnt_inc;
  logic              sat_inc;
  logic [8:0]        t_up;
  logic signed [9:0] t_dn;
  logic signed [9:0] t_raw;
  logic signed [9:0] t_lo_s;
  logic signed [9:0] t_hi_s;
  logic [7:0]        t_next;

  assign rise      = fv & ~fv_d;
  assign fall      = ~fv & fv_d;
  assign state_dbg = state;

  // Saturating corner counter; the sticky flag marks a strobe lost at full scale.
  always_comb begin
    cnt_inc = count;
    sat_inc = sat;
    if (qv) begin
      if (count == CNT_MAX) sat_inc = 1'b1;
      else                  cnt_inc = count + CNT_W'(1);
    end
  end

  // Step is applied in widened arithmetic so neither end wraps before clamping.
  always_comb begin
    t_up   = {1'b0, t} + {5'b0, step};
    t_dn   = $signed({2'b00, t}) - $signed({6'b0, step});
    t_lo_s = $signed({2'b00, t_min});
    t_hi_s = $signed({2'b00, t_max});
    if (count > target_hi)      t_raw = $signed({1'b0, t_up});
    else if (count < target_lo) t_raw = t_dn;
    else                        t_raw = $signed({2'b00, t});
    if (t_min > t_max)          t_next = t_min;
    else if (t_raw < t_lo_s)    t_next = t_min;
    else if (t_raw > t_hi_s)    t_next = t_max;
    else                        t_next = t_raw[7:0];
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fv_d          <= 1'b1;
      drain_cnt     <= '0;
      count         <= '0;
      sat           <= 1'b0;
      t             <= T_RESET;
      en            <= 1'b0;
      frame_corners <= '0;
      frame_done    <= 1'b0;
      cnt_sat       <= 1'b0;
    end else begin
      fv_d       <= fv;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!auto_en) t <= t_init;
          if (rise) begin
            state <= FRAME;
            count <= '0;
            sat   <= 1'b0;
            en    <= en_req;
          end
        end
        FRAME: begin
          count <= cnt_inc;
          sat   <= sat_inc;
          if (fall) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          count <= cnt_inc;
          sat   <= sat_inc;
          if (rise || drain_cnt == '0) state <= UPDATE;
          else                         drain_cnt <= drain_cnt - DW'(1);
        end
        UPDATE: begin
          frame_corners <= count;
          cnt_sat       <= sat;
          frame_done    <= 1'b1;
          t             <= auto_en ? t_next : t_init;
          // A frame already in progress (early drain exit or a rise here) starts immediately.
          if (fv) begin
            state <= FRAME;
            count <= '0;
            sat   <= 1'b0;
            en    <= en_req;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
